// File: rtl/fp16_mul_stream_ctrl_if.sv
// Operand/result valid-ready streams of fp16_mul_stream_ctrl.
// FP16_MUL_STREAM_TAG_EN adds in_tag/out_tag to both streams.
interface fp16_mul_stream_ctrl_if
`ifdef FP16_MUL_STREAM_TAG_EN
    #(parameter int unsigned TAG_W = 8)
`endif
    ;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
`ifdef FP16_MUL_STREAM_TAG_EN
    logic [TAG_W-1:0] in_tag;
    logic [TAG_W-1:0] out_tag;
`endif

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
`ifdef FP16_MUL_STREAM_TAG_EN
        input  in_tag,
        output out_tag,
`endif
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_a, in_b, out_ready,
`ifdef FP16_MUL_STREAM_TAG_EN
        output in_tag,
        input  out_tag,
`endif
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/fp16_mul_stream_ctrl.sv
// Credit-based valid/ready wrapper around a fixed-latency, non-stallable fp16 multiplier.
// Optional FP16_MUL_STREAM_TAG_EN carries a tag alongside every operation.
module fp16_mul_stream_ctrl #(
    parameter int unsigned LATENCY    = 11,
    parameter int unsigned FIFO_DEPTH = 16
`ifdef FP16_MUL_STREAM_TAG_EN
    ,
    parameter int unsigned TAG_W      = 8
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fp16_mul_stream_ctrl_if.slave s_if,
    output logic [15:0]           mul_a,
    output logic [15:0]           mul_b,
    input  logic [15:0]           mul_out,
    output logic                  busy
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned OCC_W = PTR_W + 2;
    // Bit 0 rides with the mul_a/mul_b register, bits 1..LATENCY with the multiplier stages.
    localparam int unsigned VP_W  = LATENCY + 1;

    logic [VP_W-1:0]  r_vpipe;
    logic [OCC_W-1:0] r_inflight;
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [15:0]      r_mul_a;
    logic [15:0]      r_mul_b;
    logic [15:0]      r_mem [FIFO_DEPTH];

    logic             w_fire;
    logic             w_capture;
    logic             w_pop;
    logic [OCC_W-1:0] w_occ;

    // Credit: every in-flight op already owns a FIFO slot, so capture can never overflow.
    assign w_occ          = r_inflight + OCC_W'(r_count);
    assign s_if.in_ready  = (w_occ < OCC_W'(FIFO_DEPTH));
    assign s_if.out_valid = (r_count != '0);
    assign s_if.out_data  = s_if.out_valid ? r_mem[r_rd_ptr] : 16'h0000;
    assign busy           = (w_occ != '0);
    assign mul_a          = r_mul_a;
    assign mul_b          = r_mul_b;

    assign w_fire    = s_if.in_valid & s_if.in_ready;
    assign w_capture = r_vpipe[VP_W-1];
    assign w_pop     = s_if.out_valid & s_if.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vpipe    <= '0;
            r_inflight <= '0;
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_mul_a    <= '0;
            r_mul_b    <= '0;
        end else begin
            r_vpipe    <= {r_vpipe[VP_W-2:0], w_fire};
            r_inflight <= r_inflight + OCC_W'(w_fire) - OCC_W'(w_capture);
            r_count    <= r_count + CNT_W'(w_capture) - CNT_W'(w_pop);
            if (w_fire) begin
                r_mul_a <= s_if.in_a;
                r_mul_b <= s_if.in_b;
            end
            if (w_capture) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
        end
    end

    // Result storage is data-only; validity comes from r_count.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_mem[r_wr_ptr] <= mul_out;
        end
    end

`ifdef FP16_MUL_STREAM_TAG_EN
    logic [TAG_W-1:0] r_tpipe [VP_W];
    logic [TAG_W-1:0] r_tmem  [FIFO_DEPTH];

    always_ff @(posedge clk) begin
        r_tpipe[0] <= s_if.in_tag;
        for (int unsigned k = 1; k < VP_W; k++) begin
            r_tpipe[k] <= r_tpipe[k-1];
        end
        if (w_capture) begin
            r_tmem[r_wr_ptr] <= r_tpipe[VP_W-1];
        end
    end

    assign s_if.out_tag = s_if.out_valid ? r_tmem[r_rd_ptr] : '0;
`endif

`ifndef SYNTHESIS
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_capture && (r_count == CNT_W'(FIFO_DEPTH)) && !w_pop));
`endif

endmodule
